lsu_bus_master: RTL and testbench

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

---
 rtl/lsu_bus_master_pkg.sv | 93 +++++++++
 rtl/lsu_bus_master_load_align.sv | 14 +
 rtl/lsu_bus_master.sv | 151 +++++++++++++++
 tb/tb_lsu_bus_master.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_bus_master_pkg.sv
// Shared encodings and helpers for the LSU bus master.
// Load/store type codes, FSM states, byte-enable, store-replicate and load-extend functions.
package lsu_bus_master_pkg;

    localparam logic [2:0] LS_WORD   = 3'b000;
    localparam logic [2:0] LS_HALF_S = 3'b001;
    localparam logic [2:0] LS_HALF_U = 3'b010;
    localparam logic [2:0] LS_BYTE_S = 3'b011;
    localparam logic [2:0] LS_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_e;

    // Codes 101..111 fall through to word.
    function automatic size_e size_of(input logic [2:0] ls);
        size_e sz;
        case (ls)
            LS_HALF_S, LS_HALF_U: sz = SZ_HALF;
            LS_BYTE_S, LS_BYTE_U: sz = SZ_BYTE;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_signed(input logic [2:0] ls);
        return (ls == LS_HALF_S) || (ls == LS_BYTE_S);
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] ls,
                                         input logic [1:0] lo);
        logic [3:0] be;
        case (size_of(ls))
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: be = 4'b0001 << lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] ls,
                                             input logic [31:0] wd);
        logic [31:0] w;
        case (size_of(ls))
            SZ_HALF: w = {wd[15:0], wd[15:0]};
            SZ_BYTE: w = {4{wd[7:0]}};
            default: w = wd;
        endcase
        return w;
    endfunction

    function automatic logic misaligned(input logic [2:0] ls,
                                        input logic [1:0] lo);
        logic m;
        case (size_of(ls))
            SZ_WORD: m = (lo != 2'b00);
            SZ_HALF: m = lo[0];
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] rdata,
                                           input logic [3:0]  be,
                                           input logic [2:0]  ls);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = be[2] ? rdata[31:16] : rdata[15:0];
        case (be)
            4'b0010: b = rdata[15:8];
            4'b0100: b = rdata[23:16];
            4'b1000: b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        case (size_of(ls))
            SZ_HALF: r = {{16{is_signed(ls) & h[15]}}, h};
            SZ_BYTE: r = {{24{is_signed(ls) & b[7]}}, b};
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_bus_master_load_align.sv
// Load lane select and sign/zero extension.
// Pure combinational: (mem_rdata, mem_be, ls_type) -> 32-bit load result.
module lsu_load_align
    import lsu_bus_master_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [3:0]  mem_be,
    input  logic [2:0]  ls_type,
    output logic [31:0] rd_data
);

    assign rd_data = extend(mem_rdata, mem_be, ls_type);

endmodule

// File: rtl/lsu_bus_master.sv
// LSU bus master: one CPU load/store per IDLE->ISSUE->WAIT->DONE pass with ack timeout.
// Define LSU_ALIGN_CHECK_EN to reject misaligned word/half accesses without a bus cycle.
module lsu_bus_master
    import lsu_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  ls_type,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        stall,
    output logic [31:0] rd,
    output logic        rd_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_e      state_q;
    state_e      state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic        we_q;
    logic [2:0]  ls_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_q;
    logic        err_q;
    logic        accept;
    logic        reject;
    logic        capture;
    logic        abort;
    logic        bad;
    logic [31:0] load_data;

`ifdef LSU_ALIGN_CHECK_EN
    assign bad = misaligned(ls_type, addr[1:0]);
`else
    assign bad = 1'b0;
`endif

    lsu_load_align u_align (
        .mem_rdata (mem_rdata),
        .mem_be    (be_q),
        .ls_type   (ls_q),
        .rd_data   (load_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        mem_req  = 1'b0;
        rd_valid = 1'b0;
        accept   = 1'b0;
        reject   = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    stall   = 1'b1;
                    accept  = 1'b1;
                    reject  = bad;
                    state_d = bad ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                cnt_d   = '0;
                if (mem_ack) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (mem_ack) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    abort   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                rd_valid = ~we_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            ls_q    <= LS_WORD;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                ls_q    <= ls_type;
                addr_q  <= {addr[31:2], 2'b00};
                be_q    <= be_of(ls_type, addr[1:0]);
                wdata_q <= wdata_of(ls_type, wd);
            end
            if (capture && !we_q) begin
                rd_q <= load_data;
            end
            // Aborted or rejected accesses report a zero result and latch err.
            if (abort || reject) begin
                rd_q  <= '0;
                err_q <= 1'b1;
            end
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign rd        = rd_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Testbench for lsu_bus_master: directed cases plus randomized loads/stores
// checked against a byte-lane arithmetic model of the access rules.
module tb_lsu_bus_master;

    localparam int TMO = 255;
`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  ls_type = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic        stall;
    logic [31:0] rd;
    logic        rd_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_rd = '0;
    logic        exp_err = 1'b0;

    lsu_bus_master #(.TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .ls_type   (ls_type),
        .addr      (addr),
        .wd        (wd),
        .stall     (stall),
        .rd        (rd),
        .rd_valid  (rd_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int nbytes(input logic [2:0] ls);
        if (ls == 3'd1 || ls == 3'd2) return 2;
        if (ls == 3'd3 || ls == 3'd4) return 1;
        return 4;
    endfunction

    // wt: cycles after ISSUE before ack (0 = ack in ISSUE), -1 = never ack.
    task automatic access(input bit we, input logic [2:0] ls,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rdat, input int wt);
        int n, off, stalls, mreqs, rdv, k, cyc, e_stalls;
        bit inflight, done, mis, hold_ok, sgn;
        logic [63:0] v, mask;
        logic [31:0] e_addr, e_wd, e_load, c_addr, c_wd;
        logic [3:0]  e_be, c_be;
        logic        c_we;
        n = nbytes(ls);
        off = (n == 4) ? 0 : (n == 2) ? (a[1] ? 2 : 0) : int'(a[1:0]);
        mis = ALIGN_EN && ((n == 4 && a[1:0] != 2'b00) || (n == 2 && a[0]));
        sgn = (ls == 3'd1) || (ls == 3'd3);
        e_addr = a & 32'hFFFF_FFFC;
        e_be = 4'(((1 << n) - 1) << off);
        e_wd = (n == 4) ? d : (n == 2) ? d[15:0] * 32'h0001_0001
                                       : d[7:0] * 32'h0101_0101;
        v = {32'b0, rdat} >> (8 * off);
        mask = (n == 4) ? 64'hFFFF_FFFF : (64'd1 << (8 * n)) - 64'd1;
        v = v & mask;
        if (sgn && v[8 * n - 1]) v = v | ~mask;
        e_load = v[31:0];
        e_stalls = mis ? 1 : 2 + ((wt < 0) ? TMO : wt);
        if (mis || wt < 0) begin
            exp_rd = '0;
            exp_err = 1'b1;
        end else if (!we) begin
            exp_rd = e_load;
        end
        stalls = 0; mreqs = 0; rdv = 0; k = 0; cyc = 0;
        inflight = 0; done = 0; hold_ok = 1;
        c_addr = 'x; c_wd = 'x; c_be = 'x; c_we = 1'bx;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; ls_type = ls; addr = a; wd = d;
        mem_ack = 1'b0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (rd_valid) rdv++;
            if (stall) stalls++;
            else begin
                done = 1;
                req_valid = 1'b0;
                check("done_rd", rd, exp_rd);
                check("done_err", {31'b0, err}, {31'b0, exp_err});
            end
            if (mem_req) begin
                mreqs++;
                inflight = 1;
                k = 0;
                c_addr = mem_addr; c_be = mem_be; c_wd = mem_wdata; c_we = mem_we;
            end else if (inflight && !done) begin
                k++;
                if (mem_addr !== c_addr || mem_be !== c_be ||
                    mem_wdata !== c_wd || mem_we !== c_we) hold_ok = 0;
            end
            mem_ack = inflight && !done && (k == wt);
            mem_rdata = mem_ack ? rdat : $urandom;
        end
        mem_ack = 1'b0;
        check("bound", {31'b0, done}, 32'd1);
        check("stall_cycles", stalls, e_stalls);
        check("mem_req_count", mreqs, mis ? 0 : 1);
        check("rd_valid_count", rdv, we ? 0 : 1);
        if (!mis) begin
            check("mem_addr", c_addr, e_addr);
            check("mem_be", {28'b0, c_be}, {28'b0, e_be});
            check("mem_wdata", c_wd, e_wd);
            check("mem_we", {31'b0, c_we}, {31'b0, we});
            check("wait_hold", {31'b0, hold_ok}, 32'd1);
        end
        @(negedge clk);
        check("idle_after", {29'b0, stall, mem_req, rd_valid}, 32'd0);
        check("rd_hold", rd, exp_rd);
    endtask

    initial begin
        #3;
        check("rst_ctl", {27'b0, stall, mem_req, mem_we, rd_valid, err}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_be_wd", {28'b0, mem_be} | mem_wdata, 32'd0);
        check("rst_rd", rd, 32'd0);
        #9 rst_n = 1'b1;

        access(1'b0, 3'b000, 32'h10, 32'h0, 32'hDEAD_BEEF, 2);
        check("word_load_rd", rd, 32'hDEAD_BEEF);
        access(1'b0, 3'b011, 32'h13, 32'h0, 32'h80FF_0000, 1);
        check("byte_s_rd", rd, 32'hFFFF_FF80);
        access(1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF_0000, 3);
        check("byte_u_rd", rd, 32'h0000_0080);
        access(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 32'h0, 2);
        access(1'b0, 3'b001, 32'h22, 32'h0, 32'h9ABC_1234, 0);
        access(1'b0, 3'b110, 32'h40, 32'h0, 32'h0BAD_F00D, 1);

        for (int i = 0; i < 40; i++) begin
            access(1'($urandom), 3'($urandom_range(0, 7)), $urandom,
                   $urandom, $urandom, $urandom_range(0, 4));
        end

        access(1'b0, 3'b000, 32'h11, 32'h0, 32'h5555_AAAA, 1);

        access(1'b0, 3'b000, 32'h80, 32'h0, 32'h0, -1);
        check("timeout_err", {31'b0, err}, 32'd1);
        check("timeout_rd", rd, 32'd0);

        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; ls_type = 3'b000; addr = 32'h44;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("midrst_ctl", {27'b0, stall, mem_req, mem_we, rd_valid, err}, 32'd0);
        check("midrst_addr", mem_addr, 32'd0);
        check("midrst_rd", rd, 32'd0);
        exp_rd = '0;
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack", {28'b0, stall, mem_req, rd_valid, err}, 32'd0);
            check("late_ack_rd", rd, 32'd0);
        end
        mem_ack = 1'b0;

        access(1'b0, 3'b010, 32'h36, 32'h0, 32'h8001_7FFF, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
